// File: rtl/alu_multicycle.sv
// Multi-cycle MIPS-style ALU: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide into HI/LO.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic [4:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOR  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_SLTU = 5'b01011;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               bz_q, bz_d;
    logic               dbz_q, dbz_d;

    logic               is_long;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // MULT/MULTU/DIV/DIVU are 100xx; bit 0 clear means signed
    assign is_long = (sel[4:2] == 3'b100);
    assign neg_a   = ~sel[0] & a[WIDTH-1];
    assign neg_b   = ~sel[0] & b[WIDTH-1];
    assign mag_a   = neg_a ? -a : a;
    assign mag_b   = neg_b ? -b : b;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign y           = y_q;
    assign zero        = ~|y_q;
    assign div_by_zero = dbz_q;

    // Single-cycle result decode
    always_comb begin
        alu_res = '0;
        case (sel)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // One multiply/divide iteration and the final sign fix-up
    always_comb begin
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        mul_nxt  = p_q[0] ? {mul_sum, p_q[WIDTH-1:1]}
                          : {1'b0, p_q[2*WIDTH-1:1]};
        rem_sh   = p_q[2*WIDTH-1:WIDTH-1];
        rem_sub  = rem_sh[WIDTH-1:0] - m_q;
        div_nxt  = (rem_sh >= {1'b0, m_q})
                 ? {rem_sub, p_q[WIDTH-2:0], 1'b1}
                 : {p_q[2*WIDTH-2:0], 1'b0};
        prod_fix = (sa_q ^ sb_q) ? -mul_nxt : mul_nxt;
        quo_fix  = (sa_q ^ sb_q) ? -div_nxt[WIDTH-1:0]
                                 : div_nxt[WIDTH-1:0];
        rem_fix  = sa_q ? -div_nxt[2*WIDTH-1:WIDTH]
                        : div_nxt[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        y_d     = y_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_long) begin
                        state_d = sel[1] ? DIV : MUL;
                        cnt_d   = '0;
                        p_d     = {{WIDTH{1'b0}}, mag_a};
                        m_d     = mag_b;
                        a_d     = a;
                        sa_d    = neg_a;
                        sb_d    = neg_b;
                        bz_d    = (b == '0);
                    end else begin
                        state_d = DONE;
                        y_d     = alu_res;
                    end
                end
            end
            MUL: begin
                p_d   = mul_nxt;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = prod_fix[WIDTH-1:0];
                    y_d     = prod_fix[WIDTH-1:0];
                end
            end
            DIV: begin
                p_d   = div_nxt;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    dbz_d   = bz_q;
                    hi_d    = bz_q ? a_q : rem_fix;
                    lo_d    = bz_q ? '1 : quo_fix;
                    y_d     = bz_q ? '1 : quo_fix;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            y_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            y_q     <= y_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits, legal values 8..64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A (rs).
REQ-008 b  input  WIDTH  operand B (rt); this is the shifted operand.
REQ-009 shamt  input  SHW  shift amount.
REQ-010 sel  input  5  operation code.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 y  output  WIDTH  result.
REQ-014 zero  output  1  high when y is all-zero.
REQ-015 div_by_zero  output  1  high with a DIV/DIVU result whose b was 0.

Function
REQ-016 sel encodings:
- 00000 AND; 00001 OR; 00100 XOR; 00101 NOR
- 00010 ADD; 00110 SUB; 00111 SLT signed; 01011 SLTU
- 01000 SLL; 01001 SRL; 01010 SRA
- 10000 MULT; 10001 MULTU; 10010 DIV; 10011 DIVU
- 10100 MFHI; 10101 MFLO
- any other code: y=0.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; overflow is not flagged.
REQ-018 SLT/SLTU set y={0..0,1} if a<b (signed/unsigned), else 0.
REQ-019 Shifts operate on b by shamt; SRA fills with b[WIDTH-1].
REQ-020 FSM states:
- IDLE: in_ready=1.
- MUL: iterative shift-add, exactly WIDTH cycles.
- DIV: restoring divide, exactly WIDTH cycles.
- DONE: out_valid=1, outputs held stable.
REQ-021 Acceptance occurs on a cycle with in_valid && in_ready; operands and sel are captured at that edge and later input changes are ignored.
REQ-022 Single-cycle ops (all except MULT/MULTU/DIV/DIVU) go from IDLE to DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-023 MULT/MULTU and DIV/DIVU go IDLE->MUL or IDLE->DIV, then to DONE after WIDTH cycles; out_valid rises WIDTH+1 cycles after acceptance.
REQ-024 DONE->IDLE on out_ready; results persist until then (backpressure), and in_ready stays low outside IDLE.
REQ-025 Internal HI/LO registers (WIDTH each) are written once, on entry to DONE from MUL/DIV:
- MULT/MULTU: {HI,LO} = 2*WIDTH-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
REQ-026 MULT/MULTU/DIV/DIVU return y=LO; MFHI/MFLO return the current HI/LO with latency 1.
REQ-027 Signed MULT/DIV use operand magnitudes, then correct signs:
- product sign = a^b sign;
- quotient sign = a^b sign;
- remainder sign = a sign.
REQ-028 Signed DIV of most-negative by -1: LO=most-negative, HI=0.
REQ-029 Divide by zero (b=0):
- LO = all ones, HI = a;
- div_by_zero=1 in DONE; 0 at all other times.
REQ-030 zero is computed from the registered y and is valid whenever out_valid=1.
REQ-031 An unrecognised sel completes in one cycle with y=0, zero=1, and HI/LO unchanged.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, out_valid=0, y=0, zero=1, div_by_zero=0, HI=LO=0, in_ready=1 (after release).
REQ-033 Reset asserted mid-MUL/DIV aborts the operation and leaves HI/LO at 0; no out_valid follows after release.

Verification
REQ-034 ADD a=0x7FFFFFFF, b=1 -> y=0x80000000, zero=0, one cycle after acceptance; SUB a=5, b=5 -> y=0, zero=1.
REQ-035 SRA b=0x80000000, shamt=4 -> y=0xF8000000; SLT a=0xFFFFFFFF, b=1 -> y=1; SLTU with the same operands -> y=0.
REQ-036 MULT a=0xFFFFFFFE (-2), b=3:
- out_valid exactly 33 cycles after acceptance, y=0xFFFFFFFA;
- MFHI -> 0xFFFFFFFF.
REQ-037 DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU a=7, b=0 -> y=0xFFFFFFFF, div_by_zero=1, MFHI -> 7.
REQ-038 Backpressure: out_ready held low 10 cycles in DONE -> y stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-039 rst_n pulsed low at cycle 10 of a MULTU:
- out_valid=0 and HI=LO=0 immediately;
- after release, in_ready=1 and the next ADD completes normally.
